lcd_spi9_rx: RTL and testbench
==============================

// Module: lcd_spi9_rx
// PURPOSE
// - Panel-side end of the 3-wire 9-bit LCD serial link: deserialises {D/C, D[7:0]} frames sent by the TFT driver.
// - Optionally answers read commands by driving SDA back MSB-first.
// - Used as the on-chip panel model / loopback checker and as the front end of the emulated LCD register file.
// - All link inputs are asynchronous to clk and are oversampled (driver SCL = clk/8).
// PARAMETERS
// - SYNC_STAGES  2   synchroniser depth on cs_n/scl/sda (>=2)
// - TX_W         32  max read-response width in bits
// PORTS
// - clk          in   1     system clock
// - rst_n        in   1     asynchronous, active-low reset
// - spi_cs_n     in   1     chip select from driver, low = active
// - spi_scl      in   1     serial clock from driver
// - spi_sda_i    in   1     serial data from driver
// - rx_valid     out  1     1-cycle pulse: rx_dc/rx_data hold a new frame
// - rx_dc        out  1     frame bit 8: 0 = command, 1 = data
// - rx_data      out  8     frame bits 7..0
// - rx_err       out  1     1-cycle pulse: CS deasserted mid-frame
// - tx_load      in   1     request to answer the last command frame
// - tx_data      in   TX_W  response data, right-aligned
// - tx_bits      in   6     response length 1..TX_W; 0 = ignore the load
// - sda_o        out  1     response data to the pad
// - sda_oe       out  1     pad output enable
// - busy         out  1     high while cs_n is low (synchronised)
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; counters and shift registers 0. Asserting reset mid-frame discards the partial frame and releases sda_oe immediately.
// - Sync and edges: cs_n, scl and sda each pass through SYNC_STAGES flops. scl_rise/scl_fall come from the last two synchronised scl samples. sda is sampled on scl_rise.
// - State IDLE (cs high): on synchronised cs falling edge -> RX with bit_cnt = 0.
// - State RX: each scl_rise shifts sda into a 9-bit shift register (MSB first) and increments bit_cnt.
//   - On the 9th bit, the next cycle pulses rx_valid with rx_dc/rx_data loaded, and bit_cnt wraps to 0.
//   - Back-to-back frames without a CS toggle are legal.
//   - rx_dc/rx_data hold until the next frame.
// - Read window: opens on the rx_valid cycle of a frame with rx_dc = 0, and closes at the next scl_rise or cs rise.
//   - tx_load with tx_bits != 0 inside the window -> TX. On the next cycle: sda_oe = 1, sda_o = tx_data[tx_bits-1].
//   - tx_load outside the window, after a data frame, or with tx_bits = 0 is ignored.
// - State TX:
//   - each scl_fall presents the next lower bit;
//   - each scl_rise decrements the remaining count and does not shift into RX;
//   - after tx_bits rises, the following scl_fall sets sda_oe = 0 and returns to RX with bit_cnt = 0.
// - CS rise in any state -> IDLE next cycle and sda_oe = 0.
//   - If in RX with bit_cnt != 0, or in TX with bits remaining: rx_err pulses for 1 cycle and no rx_valid is issued.
//   - CS rise with bit_cnt = 0 is a clean end: no rx_err.
// - Simultaneous CS rise and the 9th scl_rise in the same cycle: the frame completes (rx_valid) and there is no rx_err.
// - Latency: rx_valid fires SYNC_STAGES+2 clk after the pad-level 9th SCL rise.
// - busy = ~synchronised cs_n.
// STRUCTURE
// - Shared package lcd_spi_pkg:
//   - LCD_WORD_BITS = 9; DC_CMD = 0; DC_DATA = 1;
//   - state encodings ST_IDLE / ST_RX / ST_TX;
//   - common read opcodes (RDDID 0x04, RDDST 0x09, RDDPM 0x0A) for benches.
// - Sub-module lcd_sync_edge: SYNC_STAGES synchroniser plus rise/fall detector, instantiated for cs_n and scl (sda uses the synchroniser only).
// - Top: one FSM, a 9-bit RX shifter, a TX_W-bit TX shifter, and a 4-bit and a 6-bit counter.
// TESTING
// - Send {0,0x2A} -> exactly one rx_valid; rx_dc = 0, rx_data = 0x2A, rx_err never high.
// - Send {1,0x55},{1,0xAA} back-to-back in one CS -> two rx_valid pulses in order, with data 0x55 then 0xAA.
// - Raise CS after 5 bits, then send {1,0xFF} -> one rx_err pulse with no rx_valid, then rx_valid with rx_dc = 1, rx_data = 0xFF.
// - Send {0,0x0A}, tx_load with tx_data = 0x9C, tx_bits = 8 -> sda_oe high for 8 SCL periods, sda_o = 1,0,0,1,1,1,0,0, then sda_oe = 0 and the next frame decodes.
// - tx_load after {1,0x3C}, or with tx_bits = 0 -> sda_oe stays 0.
// - Assert rst_n low after 4 bits -> all outputs 0 within 1 clk; after release, {0,0x11} decodes correctly.

Source files
------------

// File: rtl/lcd_spi_pkg.sv
// rtl/lcd_spi_pkg.sv - shared constants and state encodings for the 9-bit LCD serial link
package lcd_spi_pkg;

  localparam int LCD_WORD_BITS = 9;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX   = 2'd1,
    ST_TX   = 2'd2
  } lcd_state_e;

  // Common panel read opcodes, handy for benches and register-file models.
  localparam logic [7:0] OP_RDDID = 8'h04;
  localparam logic [7:0] OP_RDDST = 8'h09;
  localparam logic [7:0] OP_RDDPM = 8'h0A;

endpackage

// File: rtl/lcd_sync_edge.sv
// rtl/lcd_sync_edge.sv - multi-flop synchroniser with rise/fall detection on the synchronised level
module lcd_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchroniser chain plus one extra flop so edges compare the last two synchronised samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/lcd_spi9_rx.sv
// rtl/lcd_spi9_rx.sv - panel-side 3-wire 9-bit LCD link receiver with optional read response
module lcd_spi9_rx
  import lcd_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TX_W        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            spi_cs_n,
  input  logic            spi_scl,
  input  logic            spi_sda_i,
  output logic            rx_valid,
  output logic            rx_dc,
  output logic [7:0]      rx_data,
  output logic            rx_err,
  input  logic            tx_load,
  input  logic [TX_W-1:0] tx_data,
  input  logic [5:0]      tx_bits,
  output logic            sda_o,
  output logic            sda_oe,
  output logic            busy
);

  localparam logic [3:0] FRAME_DONE = 4'(LCD_WORD_BITS);
  localparam logic [3:0] LAST_BIT   = 4'(LCD_WORD_BITS - 1);

  logic cs_n_s, cs_rise, cs_fall;
  logic scl_rise, scl_fall, unused_scl_lvl;
  logic sda_s, unused_sda_rise, unused_sda_fall;

  // cs_n idles high so busy reads 0 out of reset.
  lcd_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d_i(spi_cs_n),
    .q_o(cs_n_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  lcd_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_scl (
    .clk(clk), .rst_n(rst_n), .d_i(spi_scl),
    .q_o(unused_scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  lcd_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sda (
    .clk(clk), .rst_n(rst_n), .d_i(spi_sda_i),
    .q_o(sda_s), .rise_o(unused_sda_rise), .fall_o(unused_sda_fall)
  );

  lcd_state_e                 state_q, state_d;
  logic [3:0]                 bit_cnt_q, bit_cnt_d;
  logic [LCD_WORD_BITS-1:0]   rx_shift_q, rx_shift_d;
  logic [TX_W-1:0]            tx_shift_q, tx_shift_d;
  logic [5:0]                 tx_cnt_q, tx_cnt_d;
  logic                       tx_arm_q, tx_arm_d;
  logic                       win_q, win_d;
  logic                       rx_valid_q, rx_valid_d;
  logic                       rx_dc_q, rx_dc_d;
  logic [7:0]                 rx_data_q, rx_data_d;
  logic                       rx_err_q, rx_err_d;
  logic                       last_bit, tx_go;

  // State and datapath registers; async reset drops a partial frame and releases the pad at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      tx_cnt_q   <= '0;
      tx_arm_q   <= 1'b0;
      win_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_dc_q    <= 1'b0;
      rx_data_q  <= '0;
      rx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_arm_q   <= tx_arm_d;
      win_q      <= win_d;
      rx_valid_q <= rx_valid_d;
      rx_dc_q    <= rx_dc_d;
      rx_data_q  <= rx_data_d;
      rx_err_q   <= rx_err_d;
    end
  end

  // Next-state logic: frame completion, RX shifting, read-response handshake and CS teardown.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_arm_d   = tx_arm_q;
    win_d      = win_q;
    rx_valid_d = 1'b0;
    rx_dc_d    = rx_dc_q;
    rx_data_d  = rx_data_q;
    rx_err_d   = 1'b0;

    last_bit = (state_q == ST_RX) && scl_rise && (bit_cnt_q == LAST_BIT);
    tx_go    = (state_q == ST_RX) && win_q && tx_load && (tx_bits != 6'd0) &&
               (int'(tx_bits) <= TX_W) && !scl_rise && !cs_rise;

    // A full word publishes one cycle after its last bit, even if CS rose alongside it.
    if (bit_cnt_q == FRAME_DONE) begin
      rx_valid_d = 1'b1;
      rx_dc_d    = rx_shift_q[LCD_WORD_BITS-1];
      rx_data_d  = rx_shift_q[7:0];
      win_d      = (state_q == ST_RX) && (rx_shift_q[LCD_WORD_BITS-1] == DC_CMD);
      bit_cnt_d  = '0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_RX;
          bit_cnt_d = '0;
        end
      end
      ST_RX: begin
        if (scl_rise) begin
          win_d      = 1'b0;
          rx_shift_d = {rx_shift_q[LCD_WORD_BITS-2:0], sda_s};
          bit_cnt_d  = bit_cnt_q + 4'd1;
        end else if (tx_go) begin
          // Left-align so the MSB of the response is always at the top of the shifter.
          state_d    = ST_TX;
          tx_shift_d = tx_data << (TX_W - int'(tx_bits));
          tx_cnt_d   = tx_bits;
          tx_arm_d   = 1'b0;
          win_d      = 1'b0;
        end
      end
      ST_TX: begin
        // Only a fall that follows a rise advances; the trailing fall of the command word is skipped.
        if (scl_rise) begin
          if (tx_cnt_q != 6'd0) tx_cnt_d = tx_cnt_q - 6'd1;
          tx_arm_d = 1'b1;
        end else if (scl_fall && tx_arm_q) begin
          tx_arm_d = 1'b0;
          if (tx_cnt_q == 6'd0) begin
            state_d   = ST_RX;
            bit_cnt_d = '0;
          end else begin
            tx_shift_d = tx_shift_q << 1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cs_rise) begin
      state_d = ST_IDLE;
      win_d   = 1'b0;
      if (state_q == ST_RX && bit_cnt_q != 4'd0 && bit_cnt_q != FRAME_DONE && !last_bit) begin
        rx_err_d  = 1'b1;
        bit_cnt_d = '0;
      end
      if (state_q == ST_TX && tx_cnt_q != 6'd0) begin
        rx_err_d = 1'b1;
      end
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_dc    = rx_dc_q;
  assign rx_data  = rx_data_q;
  assign rx_err   = rx_err_q;
  assign sda_oe   = (state_q == ST_TX);
  assign sda_o    = (state_q == ST_TX) & tx_shift_q[TX_W-1];
  assign busy     = ~cs_n_s;

endmodule

// File: tb/tb_lcd_spi9_rx.sv
// tb/tb_lcd_spi9_rx.sv - directed self-checking bench for lcd_spi9_rx
module tb_lcd_spi9_rx;
  import lcd_spi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_cs_n, spi_scl, spi_sda_i;
  logic        rx_valid, rx_dc, rx_err;
  logic [7:0]  rx_data;
  logic        tx_load;
  logic [31:0] tx_data;
  logic [5:0]  tx_bits;
  logic        sda_o, sda_oe, busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int valid_cyc = 0;
  int err_cnt = 0;
  int oe_cyc = 0;
  logic [8:0] rx_q[$];

  lcd_spi9_rx #(.SYNC_STAGES(2), .TX_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_cs_n(spi_cs_n), .spi_scl(spi_scl), .spi_sda_i(spi_sda_i),
    .rx_valid(rx_valid), .rx_dc(rx_dc), .rx_data(rx_data), .rx_err(rx_err),
    .tx_load(tx_load), .tx_data(tx_data), .tx_bits(tx_bits),
    .sda_o(sda_o), .sda_oe(sda_oe), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record decoded frames, error pulses and pad-drive cycles away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        rx_q.push_back({rx_dc, rx_data});
        valid_cyc = cyc;
      end
      if (rx_err) err_cnt++;
      if (sda_oe) oe_cyc++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic spi_bit(input logic b);
    spi_sda_i = b;
    repeat (4) @(negedge clk);
    spi_scl  = 1'b1;
    rise_cyc = cyc;
    repeat (4) @(negedge clk);
    spi_scl = 1'b0;
  endtask

  task automatic send_frame(input logic [8:0] f);
    for (int i = 8; i >= 0; i--) spi_bit(f[i]);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [31:0] d, input logic [5:0] n);
    tx_data = d;
    tx_bits = n;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic read_bits(input int n, output logic [31:0] val, output int oe_n);
    val  = '0;
    oe_n = 0;
    for (int i = 0; i < n; i++) begin
      repeat (4) @(negedge clk);
      val = {val[30:0], sda_o};
      if (sda_oe) oe_n++;
      spi_scl = 1'b1;
      repeat (4) @(negedge clk);
      spi_scl = 1'b0;
    end
  endtask

  logic [31:0] rd;
  int          oe_n;
  int          oe_before;

  initial begin
    rst_n = 1'b0; spi_cs_n = 1'b1; spi_scl = 1'b0; spi_sda_i = 1'b0;
    tx_load = 1'b0; tx_data = '0; tx_bits = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {20'd0, rx_valid, rx_dc, rx_data, rx_err, sda_o, sda_oe, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single command word, clean CS end, latency from pad rise.
    rx_q.delete();
    cs_low();
    check_eq("busy_cs_low", {31'd0, busy}, 32'd1);
    send_frame({DC_CMD, 8'h2A});
    cs_high();
    check_eq("t1_count", rx_q.size(), 32'd1);
    check_eq("t1_frame", {23'd0, rx_q[0]}, 32'h02A);
    check_eq("t1_no_err", err_cnt, 32'd0);
    check_eq("t1_latency", valid_cyc - rise_cyc, 32'd4);
    check_eq("busy_cs_high", {31'd0, busy}, 32'd0);

    // Back-to-back data words inside one CS.
    rx_q.delete();
    cs_low();
    send_frame({DC_DATA, 8'h55});
    send_frame({DC_DATA, 8'hAA});
    cs_high();
    check_eq("t2_count", rx_q.size(), 32'd2);
    check_eq("t2_first", {23'd0, rx_q[0]}, 32'h155);
    check_eq("t2_second", {23'd0, rx_q[1]}, 32'h1AA);

    // Abort after 5 bits, then a full word.
    rx_q.delete();
    cs_low();
    for (int i = 0; i < 5; i++) spi_bit(i[0]);
    cs_high();
    check_eq("t3_err_pulse", err_cnt, 32'd1);
    check_eq("t3_no_valid", rx_q.size(), 32'd0);
    cs_low();
    send_frame({DC_DATA, 8'hFF});
    cs_high();
    check_eq("t3_count", rx_q.size(), 32'd1);
    check_eq("t3_frame", {23'd0, rx_q[0]}, 32'h1FF);
    check_eq("t3_err_total", err_cnt, 32'd1);

    // Read command answered with 0x9C over 8 bits, then the link resumes.
    rx_q.delete();
    cs_low();
    send_frame({DC_CMD, OP_RDDPM});
    check_eq("t4_oe_idle", {31'd0, sda_oe}, 32'd0);
    pulse_load(32'h0000_009C, 6'd8);
    read_bits(8, rd, oe_n);
    check_eq("t4_oe_bits", oe_n, 32'd8);
    check_eq("t4_sda_bits", rd, 32'h9C);
    repeat (8) @(negedge clk);
    check_eq("t4_oe_release", {31'd0, sda_oe}, 32'd0);
    send_frame({DC_DATA, 8'h5A});
    cs_high();
    check_eq("t4_count", rx_q.size(), 32'd2);
    check_eq("t4_after_tx", {23'd0, rx_q[1]}, 32'h15A);
    check_eq("t4_no_err", err_cnt, 32'd1);

    // Loads that must be ignored: after a data word, and with zero length.
    oe_before = oe_cyc;
    cs_low();
    send_frame({DC_DATA, 8'h3C});
    pulse_load(32'hFFFF_FFFF, 6'd8);
    repeat (12) @(negedge clk);
    check_eq("t5_data_ignored", oe_cyc - oe_before, 32'd0);
    send_frame({DC_CMD, OP_RDDID});
    pulse_load(32'hFFFF_FFFF, 6'd0);
    repeat (12) @(negedge clk);
    check_eq("t5_zero_ignored", oe_cyc - oe_before, 32'd0);
    cs_high();

    // Reset in the middle of a response: everything drops at once.
    rx_q.delete();
    cs_low();
    send_frame({DC_CMD, OP_RDDST});
    pulse_load(32'h0000_00A5, 6'd8);
    read_bits(4, rd, oe_n);
    check_eq("t6_oe_active", {31'd0, sda_oe}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_reset_outputs", {20'd0, rx_valid, rx_dc, rx_data, rx_err, sda_o, sda_oe, busy}, 32'd0);
    spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rx_q.delete();
    err_cnt = 0;
    cs_low();
    send_frame({DC_CMD, 8'h11});
    cs_high();
    check_eq("t6_count", rx_q.size(), 32'd1);
    check_eq("t6_frame", {23'd0, rx_q[0]}, 32'h011);
    check_eq("t6_no_err", err_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
